// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate sequencing controller.
package rot_pkg;

    localparam int unsigned W = 8;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_ROR1 = 2'b01,
        MODE_ROR2 = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ROT2 = 3'd2,
        ST_ROT1 = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/rot_seq_ctrl.sv
// Sequences an external mode-select register through load, rotate-by-2 and
// rotate-by-1 steps so its output ends up rotated right by the requested amount.
module rot_seq_ctrl
    import rot_pkg::*;
#(
    parameter int unsigned W  = rot_pkg::W,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_data,
    input  logic [AW-1:0] req_amt,
    output logic [1:0]    mode,
    output logic [W-1:0]  sln,
    input  logic [W-1:0]  po,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data
);

    localparam int unsigned CW = AW - 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          odd_q, odd_d;
    logic [W-1:0]  data_q, data_d;
    logic          live_q;
    mode_e         mode_c;

    // State, step counter, odd flag and captured operand.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            odd_q   <= 1'b0;
            data_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            odd_q   <= odd_d;
            data_q  <= data_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic; rotate-by-2 steps first, then at most one rotate-by-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        odd_d   = odd_q;
        data_d  = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && live_q) begin
                    state_d = ST_LOAD;
                    cnt_d   = req_amt[AW-1:1];
                    odd_d   = req_amt[0];
                    data_d  = req_data;
                end
            end
            ST_LOAD: begin
                if (cnt_q != '0) begin
                    state_d = ST_ROT2;
                end else if (odd_q) begin
                    state_d = ST_ROT1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ROT2: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = odd_q ? ST_ROT1 : ST_DONE;
                end
            end
            ST_ROT1: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    odd_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; ready is held low until the first edge after reset.
    always_comb begin
        mode_c    = MODE_HOLD;
        sln       = '0;
        res_valid = 1'b0;
        res_data  = '0;
        req_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = live_q;
            ST_LOAD: begin
                mode_c = MODE_LOAD;
                sln    = data_q;
            end
            ST_ROT2: mode_c = MODE_ROR2;
            ST_ROT1: mode_c = MODE_ROR1;
            ST_DONE: begin
                res_valid = 1'b1;
                res_data  = po;
            end
            default: mode_c = MODE_HOLD;
        endcase
    end

    assign mode = mode_c;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Directed bench for rot_seq_ctrl with a behavioural model of the downstream
// mode-select rotate register closing the po feedback loop.
module tb_rot_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [2:0] req_amt = 3'd0;
    logic [1:0] mode;
    logic [7:0] sln;
    logic [7:0] po;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] res;
        int         lat;
        logic [9:0] seq;   // expected modes, first step in the top two bits
    } vec_t;

    vec_t vecs[8];

    rot_seq_ctrl #(.W(8), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .mode      (mode),
        .sln       (sln),
        .po        (po),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    // Downstream register: hold, ror1, ror2, load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            po <= 8'h00;
        end else begin
            case (mode)
                2'b01:   po <= {po[0], po[7:1]};
                2'b10:   po <= {po[1:0], po[7:2]};
                2'b11:   po <= sln;
                default: po <= po;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic exp_cyc(input string tag, input logic [1:0] m, input logic [7:0] s,
                           input logic rv, input logic [7:0] rd, input logic rdy);
        check({tag, ".mode"},      32'(mode),      32'(m));
        check({tag, ".sln"},       32'(sln),       32'(s));
        check({tag, ".res_valid"}, 32'(res_valid), 32'(rv));
        check({tag, ".res_data"},  32'(res_data),  32'(rd));
        check({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
    endtask

    // Issue one request, walk every busy cycle, optionally stall in DONE.
    task automatic run_vec(input string tag, input vec_t v, input int stall);
        check({tag, ".ready_pre"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = v.data;
        req_amt   = v.amt;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < v.lat; k++) begin
            exp_cyc($sformatf("%s.step%0d", tag, k), v.seq[9-2*k -: 2],
                    (k == 0) ? v.data : 8'h00, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k < stall; k++) begin
            exp_cyc($sformatf("%s.stall%0d", tag, k), 2'b00, 8'h00, 1'b1, v.res, 1'b0);
            @(negedge clk);
        end
        exp_cyc({tag, ".done"}, 2'b00, 8'h00, 1'b1, v.res, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cyc({tag, ".idle"}, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 3'd0, 8'hA5, 1, 10'b11_00_00_00_00};
        vecs[1] = '{8'h81, 3'd3, 8'h30, 3, 10'b11_10_01_00_00};
        vecs[2] = '{8'h01, 3'd7, 8'h02, 5, 10'b11_10_10_10_01};
        vecs[3] = '{8'h96, 3'd2, 8'hA5, 2, 10'b11_10_00_00_00};
        vecs[4] = '{8'h3C, 3'd1, 8'h1E, 2, 10'b11_01_00_00_00};
        vecs[5] = '{8'hF0, 3'd4, 8'h0F, 3, 10'b11_10_10_00_00};
        vecs[6] = '{8'h12, 3'd5, 8'h90, 4, 10'b11_10_10_01_00};
        vecs[7] = '{8'h80, 3'd6, 8'h02, 4, 10'b11_10_10_10_00};

        // Reset state and ready after release
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_cyc("reset", 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Table of rotate amounts 0..7
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i], 0);
        end

        // Consumer stalls four cycles in DONE
        run_vec("stall", vecs[1], 4);

        // Request presented while busy is not taken until back in IDLE
        req_valid = 1'b1; req_data = 8'h01; req_amt = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        exp_cyc("busy.load", 2'b11, 8'h01, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("busy.rot2a", 2'b10, 8'h00, 1'b0, 8'h00, 1'b0);
        req_valid = 1'b1; req_data = 8'h55; req_amt = 3'd1;
        @(negedge clk);
        exp_cyc("busy.rot2b", 2'b10, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("busy.rot2c", 2'b10, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("busy.rot1", 2'b01, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("busy.done", 2'b00, 8'h00, 1'b1, 8'h02, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cyc("busy.idle", 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        exp_cyc("next.load", 2'b11, 8'h55, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("next.rot1", 2'b01, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("next.done", 2'b00, 8'h00, 1'b1, 8'hAA, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cyc("next.idle", 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of ROT2 aborts the request
        req_valid = 1'b1; req_data = 8'h81; req_amt = 3'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        exp_cyc("abort.rot2", 2'b10, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        #1;
        exp_cyc("abort.now", 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        exp_cyc("abort.held", 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_cyc($sformatf("abort.after%0d", k), 2'b00, 8'h00, 1'b0, 8'h00, 1'b1);
        end
        run_vec("fresh", vecs[4], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rot_seq_ctrl.md
ROT_SEQ_CTRL -- requirements
Module: rot_seq_ctrl

Interface
REQ-001 SHALL provide parameter W, default 8: data width of the 8-bit mode-select rotate register it drives; only 8 is supported.
REQ-002 SHALL provide parameter AW, default 3: rotate-amount width, equal to log2(W).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-007 SHALL have port req_data, input, W bits: value to rotate.
REQ-008 SHALL have port req_amt, input, AW bits: rotate-right amount, 0..7.
REQ-009 SHALL have port mode, output, 2 bits: mode select to the downstream register (00 hold/pass PI, 01 rotate right 1, 10 rotate right 2, 11 load sln).
REQ-010 SHALL have port sln, output, W bits: load value to the downstream register.
REQ-011 SHALL have port po, input, W bits: downstream register output; the system also feeds it back to the register's PI.
REQ-012 SHALL have port res_valid, output, 1 bit: a result is present.
REQ-013 SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port res_data, output, W bits: rotated result.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, ROT2, ROT1 and DONE.
REQ-016 SHALL assert req_ready only in IDLE, and SHALL accept a request on an edge where req_valid and req_ready are both 1.
REQ-017 On accept, SHALL capture req_data and req_amt and go to LOAD.
REQ-018 SHALL set step counter = req_amt>>1 and the odd flag = req_amt[0] on accept.
REQ-019 In LOAD, SHALL drive mode=11 and sln=captured data for exactly one cycle.
REQ-020 From LOAD, SHALL go to ROT2 if counter>0, else to ROT1 if odd, else to DONE.
REQ-021 In ROT2, SHALL drive mode=10, decrement the counter each cycle, and leave when it reaches 0 (to ROT1 if odd, else DONE).
REQ-022 In ROT1, SHALL drive mode=01 for exactly one cycle, then go to DONE.
REQ-023 In IDLE and DONE, SHALL drive mode=00; sln SHALL be 0 outside LOAD.
REQ-024 In DONE, SHALL assert res_valid with res_data=po, hold both stable until res_ready=1, then return to IDLE on that edge.
REQ-025 Accept-to-res_valid latency SHALL be 1 + (amt>>1) + amt[0] cycles, i.e. 1 cycle for amt=0 and 5 cycles for amt=7.
REQ-026 SHALL ignore req_valid while busy (LOAD through DONE), with req_ready=0 throughout.
REQ-027 No accept SHALL occur in the same cycle that DONE completes; the earliest next accept is the cycle after return to IDLE.
REQ-028 Result SHALL equal req_data rotated right by req_amt, mod W.

Reset
REQ-029 While rst=0, the FSM SHALL be in IDLE with counter=0, odd=0, mode=00, sln=0, res_valid=0, res_data=0 (gated) and req_ready=0.
REQ-030 After rst deasserts, req_ready SHALL be 1 from the first clock edge.
REQ-031 Reset asserted mid-operation SHALL abort immediately, and no result SHALL be produced for the aborted request.

Structure
REQ-032 Shared package rot_pkg SHALL hold the mode enum (MODE_HOLD, MODE_ROR1, MODE_ROR2, MODE_LOAD), the FSM state enum, and W.
REQ-033 No sub-module SHALL be used; the counter SHALL be inline.
REQ-034 FSM outputs SHALL be Moore-decoded from state.

Verification
REQ-035 Bench SHALL cover: data=0xA5, amt=0 -> LOAD only, res_valid 1 cycle after accept, res_data=0xA5.
REQ-036 Bench SHALL cover: data=0x81, amt=3 -> mode sequence 11,10,01, res_data=0x30 after 3 cycles.
REQ-037 Bench SHALL cover: data=0x01, amt=7 -> mode sequence 11,10,10,10,01, res_data=0x02 after 5 cycles.
REQ-038 Bench SHALL cover: res_ready held 0 for 4 cycles in DONE -> res_valid, res_data and mode=00 stay stable, req_ready stays 0.
REQ-039 Bench SHALL cover: req_valid=1 during ROT2 -> not accepted; accepted only after DONE completes and the FSM is back in IDLE.
REQ-040 Bench SHALL cover: rst=0 during ROT2 -> outputs reach reset values immediately; a fresh request after release completes correctly.
